// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and helpers for the Wishbone classic master engine
package wb_pkg;

    localparam int WB_MAX_ADDR_WIDTH = 64;
    localparam int WB_MAX_DATA_WIDTH = 128;
    localparam int WB_MAX_SEL_WIDTH  = WB_MAX_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_master_state_t;

    // Sized for the widest supported bus; the engine uses the low bits only.
    typedef struct packed {
        logic                         we;
        logic [WB_MAX_ADDR_WIDTH-1:0] addr;
        logic [WB_MAX_DATA_WIDTH-1:0] wdata;
        logic [WB_MAX_SEL_WIDTH-1:0]  sel;
    } wb_req_t;

    function automatic int wb_sel_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/wb_master_engine_if.sv
// rtl/wb_master_engine_if.sv - request/response streams and Wishbone bus of the master engine
interface wb_master_engine_if
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    import wb_pkg::*;

    localparam int SEL_WIDTH = wb_sel_width(DATA_WIDTH);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [SEL_WIDTH-1:0]  req_sel;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic                  wb_cyc;
    logic                  wb_stb;
    logic                  wb_we;
    logic [ADDR_WIDTH-1:0] wb_adr;
    logic [DATA_WIDTH-1:0] wb_dat_o;
    logic [SEL_WIDTH-1:0]  wb_sel;
    logic [DATA_WIDTH-1:0] wb_dat_i;
    logic                  wb_ack;
    logic                  wb_err;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_sel,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o, wb_sel,
        input  wb_dat_i, wb_ack, wb_err
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_sel,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o, wb_sel,
        output wb_dat_i, wb_ack, wb_err
    );

endinterface

// File: rtl/wb_timeout_counter.sv
// rtl/wb_timeout_counter.sv - saturating watchdog counter, expires after TIMEOUT_CYCLES enabled edges
module wb_timeout_counter
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int             CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]  LAST  = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + CW'(1);
        end
    end

    // Combinational so the edge that completes the budget is the one that aborts.
    assign expired = enable && (count >= LAST);

endmodule

// File: rtl/wb_master_engine.sv
// rtl/wb_master_engine.sv - Wishbone classic single-cycle master; watchdog built when WB_MASTER_TIMEOUT_EN is defined
module wb_master_engine
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    wb_master_engine_if.master bus
);

    localparam int SEL_WIDTH = wb_sel_width(DATA_WIDTH);

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH > WB_MAX_DATA_WIDTH ||
        ADDR_WIDTH > WB_MAX_ADDR_WIDTH || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("wb_master_engine: unsupported parameter combination");
    end

    wb_master_state_t      state;
    wb_req_t               req_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic                  in_bus;
    logic                  timeout;
    logic                  unused_req_bits;

    assign in_bus = (state == BUS);

`ifdef WB_MASTER_TIMEOUT_EN
    wb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_bus),
        .enable  (in_bus),
        .expired (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        req_q.we    <= bus.req_we;
                        req_q.addr  <= WB_MAX_ADDR_WIDTH'(bus.req_addr);
                        req_q.wdata <= WB_MAX_DATA_WIDTH'(bus.req_wdata);
                        req_q.sel   <= WB_MAX_SEL_WIDTH'(bus.req_sel);
                        rdata_q     <= '0;
                        err_q       <= 1'b0;
                        state       <= BUS;
                    end
                end
                BUS: begin
                    // Error (bus or watchdog) takes priority over a simultaneous ack.
                    if (bus.wb_err || timeout) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        state   <= RESP;
                    end else if (bus.wb_ack) begin
                        err_q   <= 1'b0;
                        rdata_q <= req_q.we ? '0 : bus.wb_dat_i;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state == IDLE) && !rst;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    assign bus.wb_cyc   = in_bus;
    assign bus.wb_stb   = in_bus;
    assign bus.wb_we    = in_bus && req_q.we;
    assign bus.wb_adr   = in_bus ? req_q.addr[ADDR_WIDTH-1:0]  : '0;
    assign bus.wb_dat_o = in_bus ? req_q.wdata[DATA_WIDTH-1:0] : '0;
    assign bus.wb_sel   = in_bus ? req_q.sel[SEL_WIDTH-1:0]    : '0;

    assign unused_req_bits = ^req_q;

endmodule

// File: tb/tb_wb_master_engine.sv
// tb/tb_wb_master_engine.sv - scoreboard bench for wb_master_engine
module tb_wb_master_engine;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    wb_master_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    wb_master_engine #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic          cur_we;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wdata;
    logic [SW-1:0] cur_sel;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            input logic [SW-1:0] sel, input bit push,
                            input logic [DW-1:0] exp_rdata, input logic exp_err);
        int n;
        cur_we = we; cur_addr = addr; cur_wdata = wdata; cur_sel = sel;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_sel   = sel;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            tick();
            n++;
        end
        check("req_ready_wait", 64'(bus.req_ready), 64'd1);
        if (push) sb.push_back(exp_t'{exp_rdata, exp_err});
        tick();
        bus.req_valid = 1'b0;
        check("accept_cyc_stb", 64'({bus.wb_cyc, bus.wb_stb}), 64'(2'b11));
    endtask

    task automatic run_bus(input int delay, input logic [DW-1:0] dat, input logic ack,
                           input logic err, input int limit, output int cycles);
        cycles = 0;
        while (cycles < limit && bus.wb_stb) begin
            cycles++;
            check("wb_ctrl_hold", 64'({bus.wb_cyc, bus.wb_we, bus.wb_adr, bus.wb_sel}),
                  64'({1'b1, cur_we, cur_addr, cur_sel}));
            check("wb_dat_o_hold", 64'(bus.wb_dat_o), 64'(cur_wdata));
            if (cycles - 1 == delay) begin
                bus.wb_ack   = ack;
                bus.wb_err   = err;
                bus.wb_dat_i = dat;
            end
            tick();
            bus.wb_ack   = 1'b0;
            bus.wb_err   = 1'b0;
            bus.wb_dat_i = '0;
        end
        check("bus_done_cyc_valid", 64'({bus.wb_cyc, bus.wb_stb, bus.rsp_valid}), 64'(3'b001));
    endtask

    task automatic get_rsp(input int hold);
        exp_t e;
        int   n;
        check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() == 0) return;
        e = sb[0];
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", 64'(bus.rsp_valid), 64'd1);
            check("hold_rdata", 64'({bus.rsp_rdata, bus.rsp_err}), 64'({e.rdata, e.err}));
            check("hold_busy", 64'({bus.req_ready, bus.wb_cyc, bus.wb_stb}), 64'd0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        n = 0;
        while (!bus.rsp_valid && n < 200) begin
            tick();
            n++;
        end
        check("rsp_valid", 64'(bus.rsp_valid), 64'd1);
        e = sb.pop_front();
        check("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
        check("rsp_err", 64'(bus.rsp_err), 64'(e.err));
        tick();
        bus.rsp_ready = 1'b0;
        check("post_rsp_idle", 64'({bus.rsp_valid, bus.req_ready, bus.wb_cyc}), 64'(3'b010));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int cyc;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_sel   = '0;
        bus.rsp_ready = 1'b0;
        bus.wb_dat_i  = '0;
        bus.wb_ack    = 1'b0;
        bus.wb_err    = 1'b0;
        tick();
        tick();
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_rsp", 64'({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}), 64'd0);
        check("rst_wb_ctrl", 64'({bus.wb_cyc, bus.wb_stb, bus.wb_we, bus.wb_sel}), 64'd0);
        check("rst_wb_adr_dat", 64'({bus.wb_adr, bus.wb_dat_o}), 64'd0);
        rst = 1'b0;
        #1;
        check("idle_req_ready", 64'(bus.req_ready), 64'd1);

        // Read with two wait states.
        send_req(1'b0, 32'h0000_1000, '0, 4'b1111, 1'b1, 32'hDEAD_BEEF, 1'b0);
        run_bus(2, 32'hDEAD_BEEF, 1'b1, 1'b0, 50, cyc);
        check("read_stb_cycles", 64'(cyc), 64'd3);
        get_rsp(0);

        // Write with immediate ack; slave read data must not leak into the response.
        send_req(1'b1, 32'h0000_0010, 32'h1234_5678, 4'b0011, 1'b1, 32'h0, 1'b0);
        run_bus(0, 32'hFFFF_FFFF, 1'b1, 1'b0, 50, cyc);
        check("write_stb_cycles", 64'(cyc), 64'd1);
        get_rsp(0);

        // Ack and err together: err wins.
        send_req(1'b0, 32'h0000_0020, '0, 4'b1111, 1'b1, 32'h0, 1'b1);
        run_bus(1, 32'hCAFE_F00D, 1'b1, 1'b1, 50, cyc);
        check("ackerr_stb_cycles", 64'(cyc), 64'd2);
        get_rsp(0);

        // Response backpressure with a competing request waiting.
        send_req(1'b0, 32'h0000_0024, '0, 4'b1100, 1'b1, 32'h55AA_33CC, 1'b0);
        run_bus(0, 32'h55AA_33CC, 1'b1, 1'b0, 50, cyc);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h0000_0030;
        bus.req_wdata = 32'hA5A5_5A5A;
        bus.req_sel   = 4'b1111;
        get_rsp(5);
        send_req(1'b1, 32'h0000_0030, 32'hA5A5_5A5A, 4'b1111, 1'b1, 32'h0, 1'b0);
        run_bus(0, 32'h0, 1'b1, 1'b0, 50, cyc);
        check("bp_write_cycles", 64'(cyc), 64'd1);
        get_rsp(0);

        // Silent slave.
`ifdef WB_MASTER_TIMEOUT_EN
        send_req(1'b0, 32'h0000_0040, '0, 4'b1111, 1'b1, 32'h0, 1'b1);
        run_bus(-1, 32'h0, 1'b0, 1'b0, 200, cyc);
        check("timeout_stb_cycles", 64'(cyc), 64'(TO));
        get_rsp(0);
`else
        send_req(1'b0, 32'h0000_0040, '0, 4'b1111, 1'b1, 32'h0, 1'b1);
        run_bus(119, 32'h0, 1'b0, 1'b1, 200, cyc);
        check("no_timeout_stb_cycles", 64'(cyc), 64'd120);
        get_rsp(0);
`endif

        // Reset mid-cycle, then a late ack must be ignored.
        send_req(1'b0, 32'h0000_0050, '0, 4'b1111, 1'b0, 32'h0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_abort", 64'({bus.wb_cyc, bus.wb_stb, bus.rsp_valid}), 64'd0);
        bus.wb_ack   = 1'b1;
        bus.wb_dat_i = 32'hFFFF_0000;
        tick();
        bus.wb_ack   = 1'b0;
        bus.wb_dat_i = '0;
        check("late_ack_ignored", 64'({bus.wb_cyc, bus.rsp_valid, bus.req_ready}), 64'(3'b001));
        send_req(1'b0, 32'h0000_0060, '0, 4'b0001, 1'b1, 32'h0BAD_F00D, 1'b0);
        run_bus(1, 32'h0BAD_F00D, 1'b1, 1'b0, 50, cyc);
        check("post_rst_stb_cycles", 64'(cyc), 64'd2);
        get_rsp(0);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
